// File: rtl/intr_pkg.sv
// Shared types and constants for the multi-source interrupt controller.
package intr_pkg;

  // Controller sequencing: waiting, requesting the CPU, inside the ISR.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intr_state_t;

  // Register offsets from the IO base port.
  localparam logic [1:0] OFS_MASK = 2'd0;
  localparam logic [1:0] OFS_PEND = 2'd1;
  localparam logic [1:0] OFS_ID   = 2'd2;
  localparam logic [1:0] OFS_EOI  = 2'd3;

  // ACTIVE_ID value meaning "no source" (reset or spurious acknowledge).
  localparam logic [7:0] ID_NONE = 8'hFF;

endpackage

// File: rtl/intr_ctrl_if.sv
// IO port bus between the CPU (master) and a port-mapped peripheral (slave).
interface intr_ctrl_if;

  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic [7:0] IN_DATA;
  logic       IN_HIT;

  modport master (
    output IO_STRB, PORT_ID, OUT_PORT,
    input  IN_DATA, IN_HIT
  );

  modport slave (
    input  IO_STRB, PORT_ID, OUT_PORT,
    output IN_DATA, IN_HIT
  );

endinterface

// File: rtl/intr_ctrl_irq_edge_sync.sv
// Per-line two-flop synchronizer followed by a rising-edge detector.
// A line already high when reset releases produces one edge, because the
// previous-value flop starts at 0.
module irq_edge_sync #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] irq_i,
  output logic [WIDTH-1:0] edge_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic sync1_q;
      logic sync2_q;
      logic prev_q;

      // Synchronize the asynchronous line and remember last synchronized value.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          prev_q  <= 1'b0;
        end else begin
          sync1_q <= irq_i[gi];
          sync2_q <= sync1_q;
          prev_q  <= sync2_q;
        end
      end

      assign edge_o[gi] = sync2_q & ~prev_q;
    end
  endgenerate

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: edge-latched pending bits, software mask,
// single request line, fixed-priority acknowledge and end-of-interrupt gating.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int         N_SRC     = 8,
  parameter logic [7:0] PORT_BASE = 8'hF0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic             INT_ACK,
  output logic             INTR,
  intr_ctrl_if.slave       io
);

  intr_state_t      state_q, state_d;
  logic             intr_q, intr_d;
  logic             do_ack;

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] irq_edge;
  logic [N_SRC-1:0] w1c_bits;
  logic [N_SRC-1:0] avail;
  logic [N_SRC-1:0] ack_clr;
  logic [7:0]       active_id_q, active_id_d;
  logic [7:0]       win_id;

  logic [7:0]       port_ofs;
  logic             hit;
  logic             wr_mask, wr_pend, wr_eoi;
  logic [7:0]       rd_data;

  // Lowest set index wins; ID_NONE when nothing is set.
  function automatic logic [7:0] lowest_index(input logic [N_SRC-1:0] v);
    logic [7:0] idx;
    idx = ID_NONE;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  irq_edge_sync #(.WIDTH(N_SRC)) u_edge (
    .CLK    (CLK),
    .RESET  (RESET),
    .irq_i  (IRQ_IN),
    .edge_o (irq_edge)
  );

  // Port decode: 8-bit wrap-around subtraction keeps the range check simple.
  always_comb begin
    port_ofs = io.PORT_ID - PORT_BASE;
    hit      = (port_ofs[7:2] == 6'd0);
    wr_mask  = io.IO_STRB && hit && (port_ofs[1:0] == OFS_MASK);
    wr_pend  = io.IO_STRB && hit && (port_ofs[1:0] == OFS_PEND);
    wr_eoi   = io.IO_STRB && hit && (port_ofs[1:0] == OFS_EOI);
  end

  // Register next values. A same-cycle mask write or W1C is seen by the
  // acknowledge, so a cancelled request yields a spurious (ID_NONE) ack.
  always_comb begin
    mask_d   = wr_mask ? io.OUT_PORT[N_SRC-1:0] : mask_q;
    w1c_bits = wr_pend ? io.OUT_PORT[N_SRC-1:0] : '0;
    avail    = pend_q & ~w1c_bits & mask_d;
    win_id   = lowest_index(avail);
    ack_clr  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = do_ack && (win_id == 8'(i));
    end
    // New edges are OR-ed last so they win over a same-cycle clear.
    pend_d      = (pend_q & ~w1c_bits & ~ack_clr) | irq_edge;
    active_id_d = do_ack ? win_id : active_id_q;
  end

  // Data registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask_q      <= '0;
      pend_q      <= '0;
      active_id_q <= ID_NONE;
    end else begin
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      active_id_q <= active_id_d;
    end
  end

  // FSM state register; INTR is registered from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      intr_q  <= intr_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|(pend_q & mask_q)) state_d = ST_REQ;
      ST_REQ: begin
        if (INT_ACK)     state_d = ST_SERVICE;
        else if (~|avail) state_d = ST_IDLE;
      end
      ST_SERVICE: if (wr_eoi) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: acknowledge only counts while requesting.
  always_comb begin
    do_ack = (state_q == ST_REQ) && INT_ACK;
    intr_d = (state_d == ST_REQ);
  end

  assign INTR = intr_q;

  // Read mux, zero-extending the per-source registers to the bus width.
  always_comb begin
    rd_data = 8'h00;
    case (port_ofs[1:0])
      OFS_MASK: rd_data[N_SRC-1:0] = mask_q;
      OFS_PEND: rd_data[N_SRC-1:0] = pend_q;
      OFS_ID:   rd_data            = active_id_q;
      default:  rd_data            = 8'h00;
    endcase
  end

  assign io.IN_HIT  = hit;
  assign io.IN_DATA = hit ? rd_data : 8'h00;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: hand-computed expectations, immediate asserts.
module tb_intr_ctrl;

  localparam logic [7:0] P_MASK = 8'hF0;
  localparam logic [7:0] P_PEND = 8'hF1;
  localparam logic [7:0] P_ID   = 8'hF2;
  localparam logic [7:0] P_EOI  = 8'hF3;

  logic       CLK;
  logic       RESET;
  logic [7:0] IRQ_IN;
  logic       INT_ACK;
  logic       INTR;
  int         tests;
  int         fails;

  intr_ctrl_if io ();

  intr_ctrl #(.N_SRC(8), .PORT_BASE(8'hF0)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IRQ_IN  (IRQ_IN),
    .INT_ACK (INT_ACK),
    .INTR    (INTR),
    .io      (io)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_intr(input string tag, input logic exp);
    check(tag, {7'b0, INTR}, {7'b0, exp});
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] port, input logic [7:0] exp);
    io.PORT_ID = port;
    #1;
    check(tag, io.IN_DATA, exp);
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    io.IO_STRB  = 1'b1;
    io.PORT_ID  = port;
    io.OUT_PORT = data;
    tick();
    io.IO_STRB  = 1'b0;
    $display("[TB] write port=%02h data=%02h ack=%0b", port, data, INT_ACK);
  endtask

  task automatic ack();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    $display("[TB] ack");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET = 1'b1;
    IRQ_IN = 8'h00;
    INT_ACK = 1'b0;
    io.IO_STRB = 1'b0;
    io.PORT_ID = 8'h00;
    io.OUT_PORT = 8'h00;
    repeat (3) tick();
    RESET = 1'b0;

    // Reset state and decode
    chk_intr("rst_intr", 1'b0);
    chk_reg("rst_mask", P_MASK, 8'h00);
    chk_reg("rst_pend", P_PEND, 8'h00);
    chk_reg("rst_id", P_ID, 8'hFF);
    io.PORT_ID = 8'h10;
    #1;
    check("unmapped_hit", {7'b0, io.IN_HIT}, 8'h00);
    check("unmapped_data", io.IN_DATA, 8'h00);
    io.PORT_ID = P_EOI;
    #1;
    check("eoi_hit", {7'b0, io.IN_HIT}, 8'h01);

    // Latency: rise before edge k, INTR after edge k+3
    wr(P_MASK, 8'h04);
    IRQ_IN[2] = 1'b1;
    tick();
    IRQ_IN[2] = 1'b0;
    chk_intr("lat_k0", 1'b0);
    tick();
    chk_intr("lat_k1", 1'b0);
    tick();
    chk_intr("lat_k2", 1'b0);
    tick();
    chk_intr("lat_k3", 1'b1);
    ack();
    chk_intr("ack_drop", 1'b0);
    chk_reg("ack_id2", P_ID, 8'h02);
    chk_reg("ack_pend_clr", P_PEND, 8'h00);
    wr(P_EOI, 8'h00);
    tick();
    chk_intr("idle_no_pend", 1'b0);

    // Priority: bits 5 and 1 together
    wr(P_MASK, 8'hFF);
    IRQ_IN = 8'h22;
    tick();
    IRQ_IN = 8'h00;
    repeat (3) tick();
    chk_intr("prio_req", 1'b1);
    ack();
    chk_reg("prio_id1", P_ID, 8'h01);
    chk_reg("prio_pend", P_PEND, 8'h20);
    chk_intr("prio_svc", 1'b0);
    wr(P_EOI, 8'h00);
    chk_intr("eoi_edge", 1'b0);
    tick();
    chk_intr("eoi_rereq", 1'b1);
    ack();
    chk_reg("prio_id5", P_ID, 8'h05);
    chk_reg("prio_pend0", P_PEND, 8'h00);

    // Edge during SERVICE is held off until EOI
    wr(P_MASK, 8'h08);
    IRQ_IN[3] = 1'b1;
    tick();
    IRQ_IN[3] = 1'b0;
    repeat (4) tick();
    chk_intr("svc_block", 1'b0);
    chk_reg("svc_pend", P_PEND, 8'h08);
    wr(P_EOI, 8'h00);
    chk_intr("svc_eoi0", 1'b0);
    tick();
    chk_intr("svc_eoi1", 1'b1);
    ack();
    chk_reg("svc_id3", P_ID, 8'h03);
    wr(P_EOI, 8'h00);
    wr(P_EOI, 8'h00);
    tick();
    chk_intr("idle_eoi", 1'b0);
    chk_reg("idle_eoi_id", P_ID, 8'h03);

    // Masked source latches; unmask raises; W1C cancels the request
    wr(P_MASK, 8'h00);
    IRQ_IN[0] = 1'b1;
    tick();
    IRQ_IN[0] = 1'b0;
    repeat (4) tick();
    chk_reg("masked_pend", P_PEND, 8'h01);
    chk_intr("masked_intr", 1'b0);
    wr(P_MASK, 8'h01);
    chk_intr("unmask_edge", 1'b0);
    tick();
    chk_intr("unmask_req", 1'b1);
    wr(P_PEND, 8'h01);
    chk_intr("w1c_cancel", 1'b0);
    tick();
    chk_intr("w1c_idle", 1'b0);
    chk_reg("w1c_pend", P_PEND, 8'h00);

    // Spurious acknowledge: mask cleared in the same cycle as ack
    IRQ_IN[0] = 1'b1;
    tick();
    IRQ_IN[0] = 1'b0;
    repeat (3) tick();
    chk_intr("spur_req", 1'b1);
    INT_ACK = 1'b1;
    wr(P_MASK, 8'h00);
    INT_ACK = 1'b0;
    chk_intr("spur_intr", 1'b0);
    chk_reg("spur_id", P_ID, 8'hFF);
    chk_reg("spur_pend", P_PEND, 8'h01);
    wr(P_MASK, 8'h01);
    tick();
    tick();
    chk_intr("spur_in_svc", 1'b0);
    wr(P_EOI, 8'h00);
    tick();
    chk_intr("spur_eoi_req", 1'b1);
    ack();
    chk_reg("spur_id0", P_ID, 8'h00);

    // Set beats W1C in the same cycle; a held line gives a single edge
    IRQ_IN[4] = 1'b1;
    tick();
    IRQ_IN[4] = 1'b0;
    repeat (4) tick();
    chk_reg("b4_pend", P_PEND, 8'h10);
    IRQ_IN[4] = 1'b1;
    tick();
    tick();
    wr(P_PEND, 8'h10);
    chk_reg("set_wins", P_PEND, 8'h10);
    repeat (3) tick();
    wr(P_PEND, 8'h10);
    chk_reg("held_one_edge", P_PEND, 8'h00);
    wr(P_MASK, 8'h5A);
    chk_reg("mask_rw", P_MASK, 8'h5A);

    // Reset while in SERVICE
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    chk_intr("mid_rst_intr", 1'b0);
    chk_reg("mid_rst_mask", P_MASK, 8'h00);
    chk_reg("mid_rst_pend", P_PEND, 8'h00);
    chk_reg("mid_rst_id", P_ID, 8'hFF);
    repeat (3) tick();
    chk_reg("rst_high_edge", P_PEND, 8'h10);
    chk_intr("rst_high_masked", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
